// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, CE-paced debounce FSM, registered level and strobes.
// Optional auto-repeat of PRESS while held is enabled by defining BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned CNT_WIDTH    = 3,
    parameter int unsigned ACTIVE_LOW   = 0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CE,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE
);

    typedef enum logic [1:0] {StIdleLo, StWaitHi, StIdleHi, StWaitLo} state_e;
    typedef logic [CNT_WIDTH:0] cnt_ext_t;

    localparam cnt_ext_t Target  = cnt_ext_t'(STABLE_TICKS);
    localparam logic     OneTick = (STABLE_TICKS == 1);
    localparam logic     Invert  = (ACTIVE_LOW != 0);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    cnt_ext_t             cnt_inc;
    logic                 done;
    logic                 btn_pol;
    logic                 s;
    logic                 rpt_fire;

    // ---------------------------------------------------------------------
    // Input synchroniser, free-running on every CLK
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;

    assign btn_pol = BTN ^ Invert;

    generate
        if (SYNC_STAGES > 1) begin : g_chain
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_pol};
                end
            end
        end else begin : g_single
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= btn_pol;
                end
            end
        end
    endgenerate

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt_q} + cnt_ext_t'(1);
    assign done    = (cnt_inc == Target);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    // ---------------------------------------------------------------------
    // Auto-repeat: first re-pulse after 16 CEs held, then every 4 CEs
    // ---------------------------------------------------------------------
    logic [4:0] rpt_cnt_q;
    logic       rpt_arm_q;
    logic       rel_now;
    logic [4:0] rpt_target;

    // A release completing on this CE suppresses a coincident repeat pulse.
    assign rel_now = CE && !s && (((state_q == StIdleHi) && OneTick) ||
                                  ((state_q == StWaitLo) && done));
    assign rpt_target = rpt_arm_q ? 5'd4 : 5'd16;
    assign rpt_fire   = CE && LEVEL && !rel_now && ((rpt_cnt_q + 5'd1) == rpt_target);

    always_ff @(posedge CLK) begin
        if (RESET || !LEVEL) begin
            rpt_cnt_q <= '0;
            rpt_arm_q <= 1'b0;
        end else if (CE) begin
            if (rpt_fire) begin
                rpt_cnt_q <= '0;
                rpt_arm_q <= 1'b1;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + 5'd1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Debounce FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdleLo;
            cnt_q   <= '0;
            LEVEL   <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
        end else begin
            PRESS   <= rpt_fire;
            RELEASE <= 1'b0;
            if (CE) begin
                unique case (state_q)
                    StIdleLo: begin
                        if (s) begin
                            if (OneTick) begin
                                state_q <= StIdleHi;
                                LEVEL   <= 1'b1;
                                PRESS   <= 1'b1;
                            end else begin
                                state_q <= StWaitHi;
                                cnt_q   <= CNT_WIDTH'(1);
                            end
                        end
                    end
                    StWaitHi: begin
                        if (!s) begin
                            state_q <= StIdleLo;
                            cnt_q   <= '0;
                        end else if (done) begin
                            state_q <= StIdleHi;
                            cnt_q   <= '0;
                            LEVEL   <= 1'b1;
                            PRESS   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc[CNT_WIDTH-1:0];
                        end
                    end
                    StIdleHi: begin
                        if (!s) begin
                            if (OneTick) begin
                                state_q <= StIdleLo;
                                LEVEL   <= 1'b0;
                                RELEASE <= 1'b1;
                            end else begin
                                state_q <= StWaitLo;
                                cnt_q   <= CNT_WIDTH'(1);
                            end
                        end
                    end
                    StWaitLo: begin
                        if (s) begin
                            state_q <= StIdleHi;
                            cnt_q   <= '0;
                        end else if (done) begin
                            state_q <= StIdleLo;
                            cnt_q   <= '0;
                            LEVEL   <= 1'b0;
                            RELEASE <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc[CNT_WIDTH-1:0];
                        end
                    end
                    default: begin
                        state_q <= StIdleLo;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: reset, clean press/hold/release, bounce, reset mid-count.
// A second instance with ACTIVE_LOW=1 sees the inverted pin and must track the first.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst, ce, btn, btn_n;
    logic level, press, rel;
    logic level_n, press_n, rel_n;

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int n_press = 0, n_rel = 0, n_both = 0, n_press_n = 0;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int HoldPresses = 5;
`else
    localparam int HoldPresses = 1;
`endif

    always #5 clk = ~clk;
    assign btn_n = ~btn;

    button_debounce #(
        .SYNC_STAGES(2), .STABLE_TICKS(4), .CNT_WIDTH(3), .ACTIVE_LOW(0)
    ) dut (
        .CLK(clk), .RESET(rst), .CE(ce), .BTN(btn),
        .LEVEL(level), .PRESS(press), .RELEASE(rel)
    );

    button_debounce #(
        .SYNC_STAGES(2), .STABLE_TICKS(4), .CNT_WIDTH(3), .ACTIVE_LOW(1)
    ) dut_n (
        .CLK(clk), .RESET(rst), .CE(ce), .BTN(btn_n),
        .LEVEL(level_n), .PRESS(press_n), .RELEASE(rel_n)
    );

    always @(negedge clk) begin
        if (press) n_press++;
        if (rel) n_rel++;
        if (press && rel) n_both++;
        if (press_n) n_press_n++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // CE is high on every 4th cycle (phase 3); outputs sampled 1 time unit after the edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            ce    = (phase == 3);
            phase = (phase + 1) % 4;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; btn = 1'b1; ce = 1'b0;
        #1;
        run(3);
        check("rst_level", int'(level), 0);
        check("rst_press", int'(press), 0);
        check("rst_release", int'(rel), 0);
        check("rst_level_n", int'(level_n), 0);

        rst = 1'b0; btn = 1'b0;
        run(50);
        check("idle_level", int'(level), 0);
        check("idle_press_cnt", n_press, 0);
        check("idle_rel_cnt", n_rel, 0);
        run(3);

        // Clean press: 2 sync edges, CEs at edges 4,8,12,16 -> LEVEL rises after edge 16
        btn = 1'b1;
        run(15);
        check("pre_press_level", int'(level), 0);
        check("pre_press_cnt", n_press, 0);
        run(1);
        check("press_level", int'(level), 1);
        check("press_strobe", int'(press), 1);
        check("press_no_rel", int'(rel), 0);
        check("press_level_n", int'(level_n), 1);
        check("press_strobe_n", int'(press_n), 1);
        run(1);
        check("press_one_cycle", int'(press), 0);
        check("press_level_hold", int'(level), 1);

        // Hold for 28 CEs past the flip
        run(111);
        check("hold_press_cnt", n_press, HoldPresses);
        check("hold_level", int'(level), 1);
        check("hold_rel_cnt", n_rel, 0);

        btn = 1'b0;
        run(15);
        check("pre_rel_level", int'(level), 1);
        check("pre_rel_strobe", int'(rel), 0);
        run(1);
        check("rel_level", int'(level), 0);
        check("rel_strobe", int'(rel), 1);
        check("rel_no_press", int'(press), 0);
        check("rel_level_n", int'(level_n), 0);
        run(1);
        check("rel_one_cycle", int'(rel), 0);
        check("rel_cnt", n_rel, 1);
        check("rel_press_cnt", n_press, HoldPresses);
        run(3);

        // Bounce: each level lasts one CE tick, then settles low
        btn = 1'b1; run(4);
        btn = 1'b0; run(4);
        btn = 1'b1; run(4);
        btn = 1'b0; run(20);
        check("bounce_level", int'(level), 0);
        check("bounce_press_cnt", n_press, HoldPresses);
        check("bounce_rel_cnt", n_rel, 1);

        // Reset on the CE that would have completed the count
        btn = 1'b1;
        run(15);
        check("mid_level", int'(level), 0);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_press", int'(press), 0);
        run(15);
        check("mid_fresh_level", int'(level), 0);
        check("mid_fresh_cnt", n_press, HoldPresses);
        run(1);
        check("mid_flip_level", int'(level), 1);
        check("mid_flip_press", int'(press), 1);
        run(1);

        check("never_both", n_both, 0);
        check("final_press_cnt", n_press, HoldPresses + 1);
        check("active_low_press_cnt", n_press_n, HoldPresses + 1);
        check("final_rel_n", int'(rel_n), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
